// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive-side word buffer and
// the generic word FIFO. The transmit side can reuse them.
//   BYTES_PER_WORD : number of bytes packed into one word
//   word_t         : 32-bit packed word
//   lane_t         : byte lane that the next good byte fills
//   pack_word      : builds a little-endian word from three held bytes and the last byte
package uart_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    LANE3 = 2'd3
  } lane_t;

  // The first byte received ends up in bits [7:0].
  function automatic word_t pack_word(input logic [23:0] low_bytes, input logic [7:0] last_byte);
    return {last_byte, low_bytes};
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// uart_word_fifo: generic synchronous FIFO built from a register array.
// There is no fall-through: a word pushed at edge N appears at the head after edge N.
//   clk, rstn : clock and asynchronous active-low reset
//   clr_i     : synchronous flush. It has priority over push and pop.
//   push_i    : write din_i. This is accepted when not full, or when full and popping.
//   din_i     : word to write
//   pop_i     : remove the head word. This is ignored while empty.
//   dout_o    : head word
//   full_o    : DEPTH words held
//   empty_o   : no words held
//   count_o   : number of words held, 0..DEPTH
module uart_word_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    rptr_q, rptr_d;
  logic             do_push_s;
  logic             do_pop_s;

  // The pointers carry one extra wrap bit. Equal low bits with a differing
  // wrap bit means full. Fully equal pointers mean empty.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign count_o = wptr_q - rptr_q;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  // A push into a full FIFO is legal only when a pop frees the head slot in the same cycle.
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);

  // Compute the next pointer values.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push_s) begin
        wptr_d = wptr_q + CW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (do_pop_s) begin
        rptr_d = rptr_q + CW'(1);
      end else begin
        rptr_d = rptr_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array. It is cleared on reset so that the head reads zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (!clr_i && do_push_s) begin
      mem_q[wptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/uart_rx_word_buf.sv
// uart_rx_word_buf: packs good bytes from the UART receiver into 32-bit
// little-endian words and queues them for a consumer over valid/ready.
//   clk, rstn   : clock and asynchronous active-low reset
//   rdata       : received byte
//   rdata_ready : one-cycle strobe. rdata and ferr are valid this cycle.
//   ferr        : framing error of the strobed byte
//   clr         : synchronous flush of the FIFO, the assembler and the sticky flags
//   word        : FIFO head word. It is meaningful only while word_valid is high.
//   word_valid  : FIFO non-empty
//   word_ready  : consumer takes the head word this cycle
//   count       : number of words held, 0..DEPTH
//   overflow    : sticky. A completed word was dropped because the FIFO was full.
//   frame_err   : sticky. A byte arrived with a framing error.
module uart_rx_word_buf
  import uart_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    rdata,
  input  logic          rdata_ready,
  input  logic          ferr,
  input  logic          clr,
  output word_t         word,
  output logic          word_valid,
  input  logic          word_ready,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          frame_err
);

  lane_t       lane_q, lane_d;
  logic [23:0] hold_q, hold_d;
  logic        overflow_q, overflow_d;
  logic        frame_err_q, frame_err_d;

  logic        empty_s;
  logic        full_s;
  logic        good_s;
  logic        word_done_s;
  logic        pop_s;
  logic        push_s;
  word_t       new_word_s;

  // Byte strobes and pops are both ignored during a flush cycle.
  assign good_s      = rdata_ready & ~ferr & ~clr;
  assign word_done_s = good_s & (lane_q == LANE3);
  assign pop_s       = ~empty_s & word_ready & ~clr;
  assign push_s      = word_done_s & (~full_s | pop_s);
  assign new_word_s  = pack_word(hold_q, rdata);

  // Compute the next lane, held bytes and sticky flags.
  always_comb begin
    lane_d      = lane_q;
    hold_d      = hold_q;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    if (clr) begin
      lane_d      = LANE0;
      hold_d      = 24'h0;
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
    end else if (rdata_ready) begin
      if (ferr) begin
        // A bad byte abandons the partial word so that the next good byte starts a fresh word.
        frame_err_d = 1'b1;
        lane_d      = LANE0;
      end else begin
        case (lane_q)
          LANE0: begin
            hold_d[7:0] = rdata;
            lane_d      = LANE1;
          end
          LANE1: begin
            hold_d[15:8] = rdata;
            lane_d       = LANE2;
          end
          LANE2: begin
            hold_d[23:16] = rdata;
            lane_d        = LANE3;
          end
          LANE3: begin
            lane_d = LANE0;
            if (full_s && !pop_s) begin
              overflow_d = 1'b1;
            end else begin
              overflow_d = overflow_q;
            end
          end
          default: begin
            lane_d = LANE0;
          end
        endcase
      end
    end else begin
      lane_d = lane_q;
    end
  end

  // Assembler and sticky-flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_q      <= LANE0;
      hold_q      <= 24'h0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      hold_q      <= hold_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  uart_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .clr_i   (clr),
    .push_i  (push_s),
    .din_i   (new_word_s),
    .pop_i   (pop_s),
    .dout_o  (word),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count)
  );

  assign word_valid = ~empty_s;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_word_buf.sv
// Self-checking bench for uart_rx_word_buf. A queue-based reference model
// tracks the bytes received so far, the queued words and the sticky flags.
module tb_uart_rx_word_buf;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rstn;
  logic [7:0]    rdata;
  logic          rdata_ready;
  logic          ferr;
  logic          clr;
  logic [31:0]   word;
  logic          word_valid;
  logic          word_ready;
  logic [CW-1:0] count;
  logic          overflow;
  logic          frame_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  parts[$];
  logic [31:0] mq[$];
  bit          m_ovf;
  bit          m_ferr;

  uart_rx_word_buf #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rdata       (rdata),
    .rdata_ready (rdata_ready),
    .ferr        (ferr),
    .clr         (clr),
    .word        (word),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .count       (count),
    .overflow    (overflow),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one clock cycle of inputs, advance the model, and return 1 time unit after the edge.
  task automatic drive_cycle(input bit strobe, input logic [7:0] b, input bit fe,
                             input bit rdy, input bit c);
    logic [31:0] tmp;
    @(negedge clk);
    rdata       = b;
    rdata_ready = strobe;
    ferr        = fe;
    word_ready  = rdy;
    clr         = c;
    if (c) begin
      mq.delete();
      parts.delete();
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
    end else begin
      if (rdy && mq.size() > 0) tmp = mq.pop_front();
      if (strobe) begin
        if (fe) begin
          m_ferr = 1'b1;
          parts.delete();
        end else begin
          parts.push_back(b);
          if (parts.size() == 4) begin
            tmp = {parts[3], parts[2], parts[1], parts[0]};
            if (mq.size() < DEPTH) mq.push_back(tmp);
            else m_ovf = 1'b1;
            parts.delete();
          end
        end
      end
    end
    @(posedge clk);
    #1;
    rdata_ready = 1'b0;
    word_ready  = 1'b0;
    clr         = 1'b0;
    ferr        = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rdy_last);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, w[8*i +: 8], 1'b0, (i == 3) ? rdy_last : 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; rdata = 8'h0; rdata_ready = 1'b0; ferr = 1'b0; clr = 1'b0; word_ready = 1'b0;
    mq.delete(); parts.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (word_valid !== 1'b0 || count !== '0 || overflow !== 1'b0 || frame_err !== 1'b0 || word !== 32'h0) begin
      errors++;
      $display("FAIL reset: valid=%b count=%0d ovf=%b ferr=%b word=%h, required 0 0 0 0 00000000",
               word_valid, count, overflow, frame_err, word);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic;
    drive_cycle(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h56, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    checks++;
    if (word_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid: got %b required 0", word_valid);
    end
    drive_cycle(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    checks++;
    if (word_valid !== 1'b1 || word !== 32'h12345678 || count !== CW'(1)) begin
      errors++;
      $display("FAIL basic_word: valid=%b word=%h count=%0d, required 1 12345678 1", word_valid, word, count);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (word_valid !== 1'b0 || count !== '0) begin
      errors++; $display("FAIL basic_pop: valid=%b count=%0d, required 0 0", word_valid, count);
    end
  endtask

  task automatic test_ferr;
    drive_cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++; $display("FAIL ferr_flag: got %b required 1", frame_err);
    end
    send_word(32'h04030201, 1'b0);
    checks++;
    if (count !== CW'(1) || word !== 32'h04030201 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL ferr_word: count=%0d word=%h ferr=%b, required 1 04030201 1", count, word, frame_err);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow;
    logic [31:0] gen [DEPTH+1];
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i <= DEPTH; i++) begin
      gen[i] = $urandom;
      send_word(gen[i], 1'b0);
    end
    checks++;
    if (count !== CW'(DEPTH) || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_full: count=%0d ovf=%b, required %0d 1", count, overflow, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (word_valid !== 1'b1 || word !== gen[i]) begin
        errors++; $display("FAIL ovf_order[%0d]: valid=%b word=%h, required 1 %h", i, word_valid, word, gen[i]);
      end
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (word_valid !== 1'b0 || count !== '0 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_drained: valid=%b count=%0d ovf=%b, required 0 0 1", word_valid, count, overflow);
    end
  endtask

  task automatic test_full_push_pop;
    logic [31:0] gen [DEPTH+1];
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      gen[i] = $urandom;
      send_word(gen[i], 1'b0);
    end
    gen[DEPTH] = $urandom;
    send_word(gen[DEPTH], 1'b1);
    checks++;
    if (count !== CW'(DEPTH) || overflow !== 1'b0) begin
      errors++; $display("FAIL fullpp_count: count=%0d ovf=%b, required %0d 0", count, overflow, DEPTH);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (word !== gen[i]) begin
        errors++; $display("FAIL fullpp_order[%0d]: word=%h required %h", i, word, gen[i]);
      end
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    // A simultaneous push and pop at count 1 leaves the count unchanged.
    send_word(32'hCAFEF00D, 1'b0);
    send_word(32'h0BADBEEF, 1'b1);
    checks++;
    if (count !== CW'(1) || word !== 32'h0BADBEEF) begin
      errors++; $display("FAIL pp_one: count=%0d word=%h, required 1 0badbeef", count, word);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_clr;
    drive_cycle(1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
    send_word(32'h11111111, 1'b0);
    drive_cycle(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'hE2, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'hE3, 1'b0, 1'b1, 1'b1);
    checks++;
    if (count !== '0 || word_valid !== 1'b0 || overflow !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL clr_state: count=%0d valid=%b ovf=%b ferr=%b, required 0 0 0 0", count, word_valid, overflow, frame_err);
    end
    send_word(32'h44332211, 1'b0);
    checks++;
    if (count !== CW'(1) || word !== 32'h44332211 || overflow !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL clr_word: count=%0d word=%h ovf=%b ferr=%b, required 1 44332211 0 0", count, word, overflow, frame_err);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset;
    drive_cycle(1'b1, 8'h7F, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_word($urandom, 1'b0);
    drive_cycle(1'b1, 8'h9A, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h9B, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== CW'(3) || frame_err !== 1'b1) begin
      errors++; $display("FAIL arst_pre: count=%0d ferr=%b, required 3 1", count, frame_err);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (word_valid !== 1'b0 || count !== '0 || overflow !== 1'b0 || frame_err !== 1'b0 || word !== 32'h0) begin
      errors++;
      $display("FAIL arst_async: valid=%b count=%0d ovf=%b ferr=%b word=%h, required 0 0 0 0 00000000",
               word_valid, count, overflow, frame_err, word);
    end
    mq.delete(); parts.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    send_word(32'hD4C3B2A1, 1'b0);
    checks++;
    if (count !== CW'(1) || word !== 32'hD4C3B2A1) begin
      errors++; $display("FAIL arst_post: count=%0d word=%h, required 1 d4c3b2a1", count, word);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 600; n++) begin
      drive_cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0));
      checks++;
      if (word_valid !== (mq.size() > 0) || count !== CW'(mq.size()) ||
          overflow !== m_ovf || frame_err !== m_ferr) begin
        errors++;
        $display("FAIL rand_state[%0d]: valid=%b count=%0d ovf=%b ferr=%b, required %b %0d %b %b",
                 n, word_valid, count, overflow, frame_err, (mq.size() > 0), mq.size(), m_ovf, m_ferr);
      end
      if (mq.size() > 0) begin
        checks++;
        if (word !== mq[0]) begin
          errors++; $display("FAIL rand_word[%0d]: word=%h required %h", n, word, mq[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ferr();
    test_overflow();
    test_full_push_pop();
    test_clr();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
